// File: rtl/quant_core.sv
// quant_core: forward/inverse coefficient quantiser sequencing one TU at a time; `define QUANT_CBF_EN adds the coded-block flag.
// Latency: 3 cycles from coefficient acceptance to o_valid; parameters settle PARAM_WAIT cycles after the request.
// Backpressure: none downstream; upstream throttled only by o_ready (high in RUN).
module quant_core #(
  parameter int PARAM_WAIT = 12,
  parameter int COEF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tu_start,
  input  logic [5:0]        i_qp,
  input  logic              i_type,
  input  logic              i_inverse,
  input  logic [1:0]        i_transize,
  input  logic              i_valid,
  input  logic [COEF_W-1:0] i_coef,
  input  logic [15:0]       Q,
  input  logic [27:0]       offset,
  input  logic [4:0]        shift,
  output logic              o_mod_valid,
  output logic [5:0]        o_qp,
  output logic              o_type,
  output logic              o_inverse,
  output logic [1:0]        o_transize,
  output logic              o_ready,
  output logic              o_valid,
  output logic [COEF_W-1:0] o_coef,
  output logic              o_done,
  output logic              o_cbf
);

  localparam int MAG_W  = COEF_W + 1;
  localparam int SUM_W  = MAG_W + 16;
  localparam int WCNT_W = (PARAM_WAIT > 1) ? $clog2(PARAM_WAIT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(PARAM_WAIT - 1);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, RUN, DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [WCNT_W-1:0]         wait_cnt;
  logic [9:0]                in_cnt, out_cnt, n_last;
  logic                      accept, start_acc;

  logic                      s1_vld, s1_neg;
  logic signed [MAG_W-1:0]   s1_mag;
  logic signed [15:0]        s1_q;
  logic signed [27:0]        s1_off;
  logic [4:0]                s1_shift;

  logic                      s2_vld, s2_neg;
  logic signed [SUM_W-1:0]   s2_sum;
  logic [4:0]                s2_shift;

  logic signed [MAG_W-1:0]   c_ext, c_mag;
  logic signed [SUM_W-1:0]   prod, off_ext, shifted;
  logic signed [SUM_W:0]     shx, res;
  logic [COEF_W-1:0]         clip_val;

  assign start_acc = (state == IDLE) && i_tu_start;
  assign accept    = i_valid && o_ready;

  always_comb begin
    case (o_transize)
      2'b00:   n_last = 10'd15;
      2'b01:   n_last = 10'd63;
      2'b10:   n_last = 10'd255;
      default: n_last = 10'd1023;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_tu_start) state_nxt = REQ;
      REQ:     state_nxt = LOAD;
      LOAD:    if (wait_cnt == WAIT_LAST) state_nxt = RUN;
      RUN:     if (accept && (in_cnt == n_last)) state_nxt = DRAIN;
      DRAIN:   if (o_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_mod_valid = (state == REQ);
    o_ready     = (state == RUN);
  end

  // Config is captured once per TU and held so the generator sees stable inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_qp       <= '0;
      o_type     <= 1'b0;
      o_inverse  <= 1'b0;
      o_transize <= '0;
    end else if (start_acc) begin
      o_qp       <= i_qp;
      o_type     <= i_type;
      o_inverse  <= i_inverse;
      o_transize <= i_transize;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
    end else begin
      wait_cnt <= (state == LOAD) ? wait_cnt + 1'b1 : '0;
      if (accept)  in_cnt  <= (in_cnt == n_last) ? 10'd0 : in_cnt + 10'd1;
      if (o_valid) out_cnt <= o_done ? 10'd0 : out_cnt + 10'd1;
    end
  end

  assign o_done = o_valid && (out_cnt == n_last);

  // Forward path works on magnitude so rounding is symmetric about zero.
  assign c_ext = {i_coef[COEF_W-1], i_coef};
  assign c_mag = (!o_inverse && i_coef[COEF_W-1]) ? -c_ext : c_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_neg   <= 1'b0;
      s1_mag   <= '0;
      s1_q     <= '0;
      s1_off   <= '0;
      s1_shift <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_neg   <= !o_inverse && i_coef[COEF_W-1];
        s1_mag   <= c_mag;
        s1_q     <= Q;
        s1_off   <= offset;
        s1_shift <= shift;
      end
    end
  end

  assign prod    = SUM_W'(s1_mag) * SUM_W'(s1_q);
  assign off_ext = SUM_W'(s1_off);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld   <= 1'b0;
      s2_neg   <= 1'b0;
      s2_sum   <= '0;
      s2_shift <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_neg   <= s1_neg;
        s2_sum   <= prod + off_ext;
        s2_shift <= s1_shift;
      end
    end
  end

  assign shifted = s2_sum >>> s2_shift;
  assign shx     = {shifted[SUM_W-1], shifted};
  assign res     = s2_neg ? -shx : shx;

  always_comb begin
    clip_val = res[COEF_W-1:0];
    if (!res[SUM_W] && (|res[SUM_W-1:COEF_W-1]))
      clip_val = {1'b0, {(COEF_W-1){1'b1}}};
    else if (res[SUM_W] && !(&res[SUM_W-1:COEF_W-1]))
      clip_val = {1'b1, {(COEF_W-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_coef  <= '0;
    end else begin
      o_valid <= s2_vld;
      if (s2_vld) o_coef <= clip_val;
    end
  end

`ifdef QUANT_CBF_EN
  logic cbf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cbf_q <= 1'b0;
    else if (start_acc)              cbf_q <= 1'b0;
    else if (o_valid && (|o_coef))   cbf_q <= 1'b1;
  end

  // Include the current result so the flag is complete in the o_done cycle.
  assign o_cbf = cbf_q || (o_valid && (|o_coef));
`else
  assign o_cbf = 1'b0;
`endif

endmodule

// File: tb/tb_quant_core.sv
// Bench for quant_core: randomized TUs checked against an arithmetic reference model and a cycle-accurate latency expectation.
module tb_quant_core;

  localparam int PW = 12;
`ifdef QUANT_CBF_EN
  localparam bit CBF_EN = 1'b1;
`else
  localparam bit CBF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_tu_start = 1'b0;
  logic [5:0]  i_qp = '0;
  logic        i_type = 1'b0;
  logic        i_inverse = 1'b0;
  logic [1:0]  i_transize = '0;
  logic        i_valid = 1'b0;
  logic [15:0] i_coef = '0;
  logic [15:0] Q = '0;
  logic [27:0] offset = '0;
  logic [4:0]  shift = '0;
  logic        o_mod_valid, o_type, o_inverse, o_ready, o_valid, o_done, o_cbf;
  logic [5:0]  o_qp;
  logic [1:0]  o_transize;
  logic [15:0] o_coef;

  quant_core #(.PARAM_WAIT(PW), .COEF_W(16)) dut (
    .clk(clk), .rst(rst), .i_tu_start(i_tu_start), .i_qp(i_qp), .i_type(i_type),
    .i_inverse(i_inverse), .i_transize(i_transize), .i_valid(i_valid), .i_coef(i_coef),
    .Q(Q), .offset(offset), .shift(shift), .o_mod_valid(o_mod_valid), .o_qp(o_qp),
    .o_type(o_type), .o_inverse(o_inverse), .o_transize(o_transize), .o_ready(o_ready),
    .o_valid(o_valid), .o_coef(o_coef), .o_done(o_done), .o_cbf(o_cbf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  int got_v[$];
  int got_c[$];
  int exp_v[$];
  int exp_c[$];
  int coef_in[1024];
  int done_cnt = 0, done_idx = -1, mod_cnt = 0, mod_cyc = 0, rdy_cyc = 0;
  bit done_cbf = 1'b0, rdy_prev = 1'b0;

  always @(negedge clk) begin
    if (o_valid) begin
      got_v.push_back(int'($signed(o_coef)));
      got_c.push_back(cyc);
    end
    if (o_done) begin
      done_cnt++;
      done_idx = got_v.size();
      done_cbf = o_cbf;
    end
    if (o_mod_valid) begin
      mod_cnt++;
      mod_cyc = cyc;
    end
    if (o_ready && !rdy_prev) rdy_cyc = cyc;
    rdy_prev = o_ready;
  end

  // level = sign(c)*((|c|*Q+offset)>>shift) forward; (l*Q+offset)>>>shift inverse; then saturate.
  function automatic int ref_coef(input int c, input bit inv, input int q, input int off, input int sh);
    longint a, v;
    if (inv) begin
      v = (longint'(c) * q + off) >>> sh;
    end else begin
      a = (c < 0) ? -longint'(c) : longint'(c);
      v = (a * q + off) >>> sh;
      if (c < 0) v = -v;
    end
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  task automatic fill_random(input int lo, input int hi);
    for (int i = 0; i < 1024; i++) coef_in[i] = lo + int'($urandom_range(hi - lo));
  endtask

  task automatic do_tu(input string nm, input int sz, input bit inv, input bit typ, input int qp,
                       input int q, input int off, input int sh, input int gap_pct, input bit mid_start);
    int n, acc, guard;
    bit pulsed, nz, v;
    n = 16 << (2 * sz);
    got_v.delete(); got_c.delete(); exp_v.delete(); exp_c.delete();
    done_cnt = 0; done_idx = -1; mod_cnt = 0; mod_cyc = 0; rdy_cyc = 0;
    Q = q[15:0]; offset = off[27:0]; shift = sh[4:0];
    i_qp = qp[5:0]; i_type = typ; i_inverse = inv; i_transize = sz[1:0]; i_tu_start = 1'b1;
    @(posedge clk); #1;
    i_tu_start = 1'b0;
    n_chk++;
    if ({o_qp, o_type, o_inverse, o_transize} !== {qp[5:0], typ, inv, sz[1:0]})
      $display("FAIL %s cfg_capture got %h exp %h", nm, {o_qp, o_type, o_inverse, o_transize}, {qp[5:0], typ, inv, sz[1:0]});
    else n_pass++;

    // Junk strobes before RUN must be ignored.
    guard = 0; i_valid = 1'b1; i_coef = 16'h1234;
    while (!o_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    i_valid = 1'b0;
    n_chk++;
    if (o_ready !== 1'b1) $display("FAIL %s ready_timeout got %b exp 1", nm, o_ready);
    else n_pass++;

    acc = 0; pulsed = 1'b0; guard = 0;
    while (o_ready && acc < n && guard < 20000) begin
      v = ($urandom_range(99) >= gap_pct);
      i_valid = v;
      i_coef = coef_in[acc][15:0];
      if (mid_start && !pulsed && acc == n / 2) begin
        i_tu_start = 1'b1; i_qp = ~qp[5:0]; i_transize = ~sz[1:0]; pulsed = 1'b1;
      end
      if (v) begin
        exp_v.push_back(ref_coef(coef_in[acc], inv, q, off, sh));
        exp_c.push_back(cyc + 3);
        acc++;
      end
      @(posedge clk); #1;
      i_tu_start = 1'b0; guard++;
    end

    guard = 0; i_valid = 1'b1; i_coef = 16'h0777;
    while (done_cnt == 0 && guard < 40) begin @(posedge clk); #1; guard++; end
    i_valid = 1'b0;
    @(posedge clk); #1;

    n_chk++;
    if (done_cnt !== 1) $display("FAIL %s done_count got %0d exp 1", nm, done_cnt); else n_pass++;
    n_chk++;
    if (got_v.size() !== n) $display("FAIL %s result_count got %0d exp %0d", nm, got_v.size(), n); else n_pass++;
    for (int i = 0; i < n && i < got_v.size() && i < exp_v.size(); i++) begin
      n_chk++;
      if (got_v[i] !== exp_v[i]) $display("FAIL %s value[%0d] got %0d exp %0d", nm, i, got_v[i], exp_v[i]);
      else n_pass++;
      n_chk++;
      if (got_c[i] !== exp_c[i]) $display("FAIL %s latency[%0d] got cyc %0d exp cyc %0d", nm, i, got_c[i], exp_c[i]);
      else n_pass++;
    end
    n_chk++;
    if (done_idx !== n) $display("FAIL %s done_position got %0d exp %0d", nm, done_idx, n); else n_pass++;
    n_chk++;
    if (mod_cnt !== 1) $display("FAIL %s mod_valid_pulses got %0d exp 1", nm, mod_cnt); else n_pass++;
    n_chk++;
    if (rdy_cyc - mod_cyc !== PW + 1) $display("FAIL %s req_to_ready got %0d exp %0d", nm, rdy_cyc - mod_cyc, PW + 1);
    else n_pass++;
    n_chk++;
    if ({o_ready, o_mod_valid, o_valid} !== 3'b000) $display("FAIL %s idle_after_done got %b exp 000", nm, {o_ready, o_mod_valid, o_valid});
    else n_pass++;
    n_chk++;
    if ({o_qp, o_transize} !== {qp[5:0], sz[1:0]}) $display("FAIL %s cfg_held got %h exp %h", nm, {o_qp, o_transize}, {qp[5:0], sz[1:0]});
    else n_pass++;
    nz = 1'b0;
    foreach (exp_v[i]) if (exp_v[i] != 0) nz = 1'b1;
    n_chk++;
    if (done_cbf !== (CBF_EN && nz)) $display("FAIL %s cbf got %b exp %b", nm, done_cbf, CBF_EN && nz);
    else n_pass++;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({o_valid, o_done, o_ready, o_mod_valid, o_cbf} !== 5'b0) $display("FAIL reset_strobes got %b exp 00000", {o_valid, o_done, o_ready, o_mod_valid, o_cbf});
    else n_pass++;
    n_chk++;
    if (o_coef !== 16'd0) $display("FAIL reset_coef got %0d exp 0", o_coef); else n_pass++;
    n_chk++;
    if ({o_qp, o_type, o_inverse, o_transize} !== 10'd0) $display("FAIL reset_cfg got %h exp 0", {o_qp, o_type, o_inverse, o_transize});
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward;
    fill_random(-2000, 2000);
    coef_in[0] = 100; coef_in[1] = -100; coef_in[2] = 0;
    do_tu("fwd4x4", 0, 1'b0, 1'b1, 0, 26214, 87040, 19, 0, 1'b0);
    n_chk++;
    if (got_v.size() < 3 || got_v[0] !== 5 || got_v[1] !== -5 || got_v[2] !== 0)
      $display("FAIL fwd_vectors got %0d,%0d,%0d exp 5,-5,0", got_v[0], got_v[1], got_v[2]);
    else n_pass++;
  endtask

  task automatic test_inverse;
    fill_random(-300, 300);
    coef_in[0] = 5; coef_in[1] = -5;
    do_tu("inv4x4", 0, 1'b1, 1'b0, 0, 40, 1, 1, 10, 1'b0);
    n_chk++;
    if (got_v.size() < 2 || got_v[0] !== 100 || got_v[1] !== -100)
      $display("FAIL inv_vectors got %0d,%0d exp 100,-100", got_v[0], got_v[1]);
    else n_pass++;
  endtask

  task automatic test_clip;
    fill_random(-32768, 32767);
    coef_in[0] = 32767; coef_in[1] = -32768;
    do_tu("clip32x32", 3, 1'b1, 1'b0, 51, 14592, 8, 4, 0, 1'b0);
    n_chk++;
    if (got_v.size() < 2 || got_v[0] !== 32767 || got_v[1] !== -32768)
      $display("FAIL clip_vectors got %0d,%0d exp 32767,-32768", got_v[0], got_v[1]);
    else n_pass++;
  endtask

  task automatic test_gaps;
    fill_random(-32768, 32767);
    coef_in[0] = -32768;
    do_tu("gaps8x8", 1, 1'b0, 1'b0, int'($urandom_range(51)), int'($urandom_range(1, 32767)),
          int'($urandom_range(1 << 20)), int'($urandom_range(10, 20)), 40, 1'b0);
  endtask

  task automatic test_start_ignored;
    fill_random(-1000, 1000);
    do_tu("start_in_run", 0, 1'b1, 1'b1, 30, int'($urandom_range(1, 4000)),
          int'($urandom_range(64)) - 32, int'($urandom_range(0, 6)), 20, 1'b1);
  endtask

  task automatic test_back_to_back;
    fill_random(-4000, 4000);
    do_tu("b2b_a", 0, 1'b1, 1'b0, 12, int'($urandom_range(1, 8000)), 0, 3, 0, 1'b0);
    do_tu("b2b_b", 1, 1'b0, 1'b1, 40, int'($urandom_range(1, 32767)), 5000, 14, 0, 1'b0);
  endtask

  task automatic test_reset_mid;
    int nb, guard;
    got_v.delete();
    Q = 16'd26214; offset = 28'd87040; shift = 5'd19;
    i_qp = 6'd0; i_type = 1'b1; i_inverse = 1'b0; i_transize = 2'b00; i_tu_start = 1'b1;
    @(posedge clk); #1;
    i_tu_start = 1'b0;
    guard = 0;
    while (!o_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1; i_coef = 16'd100;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    done_cnt = 0;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({o_valid, o_done, o_ready, o_mod_valid} !== 4'b0) $display("FAIL midrst_strobes got %b exp 0000", {o_valid, o_done, o_ready, o_mod_valid});
    else n_pass++;
    n_chk++;
    if ({o_coef, o_qp, o_type, o_transize} !== 25'd0) $display("FAIL midrst_data got %h exp 0", {o_coef, o_qp, o_type, o_transize});
    else n_pass++;
    nb = got_v.size();
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_chk++;
    if (got_v.size() !== nb) $display("FAIL midrst_no_results got %0d exp %0d", got_v.size(), nb); else n_pass++;
    n_chk++;
    if (done_cnt !== 0) $display("FAIL midrst_no_done got %0d exp 0", done_cnt); else n_pass++;
    fill_random(-2000, 2000);
    do_tu("after_rst", 0, 1'b0, 1'b1, 0, 26214, 87040, 19, 10, 1'b0);
  endtask

  task automatic test_cbf;
    for (int i = 0; i < 1024; i++) coef_in[i] = 0;
    do_tu("cbf_zero", 0, 1'b0, 1'b1, 0, 26214, 87040, 19, 0, 1'b0);
    n_chk++;
    if (done_cbf !== 1'b0) $display("FAIL cbf_all_zero got %b exp 0", done_cbf); else n_pass++;
    coef_in[0] = 100;
    do_tu("cbf_one", 0, 1'b0, 1'b1, 0, 26214, 87040, 19, 0, 1'b0);
    n_chk++;
    if (done_cbf !== CBF_EN) $display("FAIL cbf_single got %b exp %b", done_cbf, CBF_EN); else n_pass++;
    coef_in[0] = 0;
    do_tu("cbf_clear", 0, 1'b0, 1'b1, 0, 26214, 87040, 19, 0, 1'b0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_clip();
    test_gaps();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_cbf();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/quant_core.md
Name: quant_core

Overview:
- Coefficient datapath that consumes the quantiser parameter triple (Q, offset, shift) produced by the team's qp-to-parameter generator ("mod").
- Forward: level = sign(c)·((|c|·Q + offset) >> shift). Inverse: c' = (l·Q + offset) >>> shift.
- Sequences one TU at a time: requests parameters, waits for them to settle, then streams coefficients through a 3-stage pipeline.
- Sits between the transform/inverse-transform stage and the entropy/reconstruction path.

Parameters:
- PARAM_WAIT, 12: cycles held in LOAD after the parameter request pulse (covers qp/6 iteration, qp≤51).
- COEF_W, 16: coefficient and level width, signed.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- i_tu_start  in  1  start pulse; samples i_qp, i_type, i_inverse, i_transize
- i_qp  in  6  quantisation parameter, 0..51
- i_type  in  1  slice-type select for the forward rounding offset, forwarded to generator
- i_inverse  in  1  0 = quantise, 1 = dequantise
- i_transize  in  2  00 = 4x4, 01 = 8x8, 10 = 16x16, 11 = 32x32
- i_valid  in  1  coefficient strobe
- i_coef  in  COEF_W  signed coefficient or level
- Q  in  16  signed scale from generator
- offset  in  28  signed rounding offset from generator
- shift  in  5  right-shift amount from generator
- o_mod_valid  out  1  parameter request to generator
- o_qp  out  6  registered qp to generator
- o_type  out  1  registered type to generator
- o_inverse  out  1  registered direction to generator
- o_transize  out  2  registered size to generator
- o_ready  out  1  high in RUN; coefficients accepted only when high
- o_valid  out  1  result strobe
- o_coef  out  COEF_W  signed result, saturated
- o_done  out  1  one-cycle pulse, coincident with the last o_valid of the TU
- o_cbf  out  1  coded-block flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; pipeline valids cleared.
- Reset mid-operation discards in-flight data; no o_valid or o_done follows.
- FSM states: IDLE, REQ, LOAD, RUN, DRAIN.
  - IDLE: on i_tu_start, register the config outputs and go to REQ.
  - REQ: one cycle with o_mod_valid=1, then LOAD.
  - LOAD: count PARAM_WAIT cycles, then RUN.
  - RUN: o_ready=1; each i_valid&&o_ready accepts one coefficient and increments the input counter. Gaps in i_valid are allowed. On acceptance of coefficient N-1, go to DRAIN. N = 16, 64, 256, 1024 by size.
  - DRAIN: return to IDLE after the last result leaves stage 3.
- i_tu_start outside IDLE is ignored. i_valid outside RUN is ignored.
- Config and generator outputs are held stable from REQ until IDLE.
- Pipeline: fixed latency of 3 cycles from acceptance to o_valid; no backpressure.
  - S1: register |c| (or c if inverse), its sign, Q, offset, shift. |−32768| = 32768 held in 17 bits.
  - S2: 33-bit signed sum = product + offset.
  - S3: forward: arithmetic shift right, restore sign, clip. Inverse: arithmetic shift right of the signed sum, clip. Clip range is [−32768, 32767].
- o_done asserts with the Nth o_valid; output counter wraps to 0 after it.
- Back-to-back TUs: a new i_tu_start is accepted only in IDLE.

Optional Feature:
- QUANT_CBF_EN defined: o_cbf is sticky-set when any o_coef ≠ 0 within the TU. It is valid together with o_done and cleared on the next i_tu_start.
- QUANT_CBF_EN undefined: o_cbf is tied 0 and no flag register exists.

Test Plan:
- Forward 4x4, qp=0, type=1 (Q=26214, shift=19, offset=87040), coef 100 → 5; coef −100 → −5; coef 0 → 0. o_valid exactly 3 cycles after acceptance.
- Inverse 4x4, qp=0 (Q=40, shift=1, offset=1), level 5 → 100; level −5 → −100.
- Inverse 32x32, qp=51 (Q=14592, shift=4, offset=8), level 32767 → 32767 (clip); level −32768 → −32768 (clip).
- 8x8 TU of 64 coefficients with random i_valid gaps → exactly 64 o_valid; o_done with the 64th; FSM back in IDLE; o_mod_valid pulsed once, PARAM_WAIT cycles before o_ready rises.
- i_tu_start pulsed during RUN → ignored, count unchanged. rst low after 10 of 16 coefficients → outputs 0, no o_done; a fresh TU then completes normally.
- With QUANT_CBF_EN: all-zero TU → o_cbf=0 at o_done; a single coefficient 100 (forward qp=0) → o_cbf=1.
